// File: rtl/vga_defs_pkg.sv
// Shared VGA definitions: colour width, display geometry, frame size and scheduler state encoding.
package vga_defs;

    localparam int unsigned COLOR_W          = 9;
    localparam int unsigned H_DISPLAY        = 640;
    localparam int unsigned V_DISPLAY        = 480;
    localparam int unsigned FRAME_PIXELS_DEF = H_DISPLAY * V_DISPLAY;
    localparam int unsigned PIX_CNT_W        = 19;
    localparam int unsigned UF_CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_ARMED   = 2'd2,
        ST_STREAM  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; head is presented combinationally, zero when empty.
module vga_pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == LW'(0));
    assign full    = (count == LW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = count;
    assign dout    = empty ? WIDTH'(0) : mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vga_stream_scheduler.sv
// Pixel scheduler between the frame decoder and the VGA output stage.
// Optional underflow event counter enabled by defining VGA_SCHED_UNDERFLOW_COUNT_EN.
module vga_stream_scheduler
    import vga_defs::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned PREFILL_LEVEL = 8,
    parameter int unsigned FRAME_PIXELS  = FRAME_PIXELS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clr_status,
    input  logic [COLOR_W-1:0]            src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic                          vsync,
    input  logic                          display_active,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          color_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          underflow,
    output logic                          frame_error,
    output logic [UF_CNT_W-1:0]           underflow_count
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_e         state;
    logic                 vsync_q;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 vsync_fall;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_flush;
    logic                 push;
    logic                 pop;
    logic                 start_pop;
    logic                 drop;
    logic                 frame_ok;
    logic                 resync;
    logic [LVL_W-1:0]     next_level;

    assign vsync_fall = vsync_q & ~vsync;
    assign busy       = (state != ST_IDLE);
    assign src_ready  = (state inside {ST_PREFILL, ST_ARMED, ST_STREAM}) & ~fifo_full;
    // The ARMED->STREAM cycle already delivers the first pixel so the frame count stays exact.
    assign start_pop   = (state == ST_ARMED) & display_active;
    assign color_valid = ((state == ST_STREAM) | start_pop) & ~fifo_empty;
    assign push        = src_valid & src_ready;
    assign pop         = color_valid & display_active;
    assign drop        = (state == ST_STREAM) & display_active & fifo_empty;
    assign frame_ok    = (pix_cnt == PIX_CNT_W'(FRAME_PIXELS));
    assign resync      = (state == ST_STREAM) & vsync_fall & ~frame_ok;
    assign fifo_flush  = ~enable | (state == ST_IDLE) | resync;
    assign next_level  = LVL_W'(fifo_level) + LVL_W'(push);

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (COLOR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (fifo_flush),
        .din   (src_data),
        .dout  (color_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Scheduler state machine: prefill, arm on level, stream, resync on bad frame length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (!enable) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (vsync_fall) state <= ST_PREFILL;
                ST_PREFILL: if (next_level >= LVL_W'(PREFILL_LEVEL)) state <= ST_ARMED;
                ST_ARMED:   if (display_active) state <= ST_STREAM;
                ST_STREAM:  if (resync) state <= ST_PREFILL;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // vsync history for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b1;
        else        vsync_q <= vsync;
    end

    // Pixels delivered in the current frame; restarts at each vsync while streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (!enable || ((state == ST_STREAM) && vsync_fall)) begin
            pix_cnt <= '0;
        end else if (pop) begin
            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
        end
    end

    // Sticky status flags; a set event beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (drop)            underflow <= 1'b1;
            else if (clr_status) underflow <= 1'b0;
            if (resync)          frame_error <= 1'b1;
            else if (clr_status) frame_error <= 1'b0;
        end
    end

`ifdef VGA_SCHED_UNDERFLOW_COUNT_EN
    logic [UF_CNT_W-1:0] uf_cnt;

    // Saturating dropped-pixel counter; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt <= '0;
        end else if (clr_status) begin
            uf_cnt <= '0;
        end else if (drop && (uf_cnt != 16'hFFFF)) begin
            uf_cnt <= uf_cnt + UF_CNT_W'(1);
        end
    end

    assign underflow_count = uf_cnt;
`else
    assign underflow_count = UF_CNT_W'(0);
`endif

endmodule
